// File: rtl/ecpri_rma_resp_builder.sv
// eCPRI RMA response builder: writes a 16-byte header plus optional read payload byte-serially into the TX packet RAM.
// Latency start->done is 18 cycles (no payload) or 19+P; no backpressure, start is ignored while busy or during done.
module ecpri_rma_resp_builder #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MAX_LEN    = 1024,
    parameter int unsigned DST_BASE   = 0,
    parameter int unsigned ECPRI_REV  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            resp_type,
    input  logic [7:0]            acc_id,
    input  logic [15:0]           elem_id,
    input  logic [47:0]           rm_addr,
    input  logic [15:0]           rm_len,
    input  logic [ADDR_WIDTH-1:0] src_base,
    output logic [ADDR_WIDTH-1:0] src_addr,
    output logic                  src_oe,
    input  logic [7:0]            src_data,
    output logic [ADDR_WIDTH-1:0] dst_addr,
    output logic [7:0]            dst_data,
    output logic                  dst_we,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           pkt_len
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [7:0]            acc_id_q, acc_id_d;
    logic [15:0]           elem_id_q, elem_id_d;
    logic [47:0]           rm_addr_q, rm_addr_d;
    logic [15:0]           len_fld_q, len_fld_d;
    logic [15:0]           pay_len_q, pay_len_d;
    logic [7:0]            b5_q, b5_d;
    logic [ADDR_WIDTH-1:0] src_base_q, src_base_d;
    logic [ADDR_WIDTH-1:0] src_addr_q, src_addr_d;
    logic                  src_oe_q, src_oe_d;
    logic [ADDR_WIDTH-1:0] dst_addr_q, dst_addr_d;
    logic [7:0]            dst_data_q, dst_data_d;
    logic                  dst_we_q, dst_we_d;
    logic                  pay_wr_q, pay_wr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [15:0]           pkt_len_q, pkt_len_d;

    logic [15:0] psize;
    logic [7:0]  hdr_byte;
    logic        rd_ok;
    logic        wr_req;

    assign psize  = 16'd12 + pay_len_q;
    assign rd_ok  = (resp_type == 2'd0) && !(32'(rm_len) > MAX_LEN);
    assign wr_req = (resp_type == 2'd1);

    always_comb begin
        hdr_byte = 8'h00;
        case (cnt_q[3:0])
            4'd0:  hdr_byte = {4'(ECPRI_REV), 4'h0};
            4'd1:  hdr_byte = 8'h04;
            4'd2:  hdr_byte = psize[15:8];
            4'd3:  hdr_byte = psize[7:0];
            4'd4:  hdr_byte = acc_id_q;
            4'd5:  hdr_byte = b5_q;
            4'd6:  hdr_byte = elem_id_q[15:8];
            4'd7:  hdr_byte = elem_id_q[7:0];
            4'd8:  hdr_byte = rm_addr_q[47:40];
            4'd9:  hdr_byte = rm_addr_q[39:32];
            4'd10: hdr_byte = rm_addr_q[31:24];
            4'd11: hdr_byte = rm_addr_q[23:16];
            4'd12: hdr_byte = rm_addr_q[15:8];
            4'd13: hdr_byte = rm_addr_q[7:0];
            4'd14: hdr_byte = len_fld_q[15:8];
            4'd15: hdr_byte = len_fld_q[7:0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_id_d   = acc_id_q;
        elem_id_d  = elem_id_q;
        rm_addr_d  = rm_addr_q;
        len_fld_d  = len_fld_q;
        pay_len_d  = pay_len_q;
        b5_d       = b5_q;
        src_base_d = src_base_q;
        src_addr_d = src_addr_q;
        src_oe_d   = 1'b0;
        dst_addr_d = dst_addr_q;
        dst_data_d = dst_data_q;
        dst_we_d   = 1'b0;
        pay_wr_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pkt_len_d  = pkt_len_q;
        case (state_q)
            S_IDLE: begin
                // done_q marks the done cycle, where a new start must not be taken
                if (start && !done_q) begin
                    acc_id_d   = acc_id;
                    elem_id_d  = elem_id;
                    rm_addr_d  = rm_addr;
                    src_base_d = src_base;
                    pay_len_d  = rd_ok ? rm_len : 16'd0;
                    len_fld_d  = (rd_ok || wr_req) ? rm_len : 16'd0;
                    // Write responses never fail here, so every failure echoes a read request
                    b5_d       = rd_ok ? 8'h01 : (wr_req ? 8'h11 : 8'h02);
                    cnt_d      = 16'd0;
                    busy_d     = 1'b1;
                    pkt_len_d  = 16'd0;
                    state_d    = S_HDR;
                end
            end
            S_HDR: begin
                dst_we_d   = 1'b1;
                dst_addr_d = ADDR_WIDTH'(DST_BASE) + ADDR_WIDTH'(cnt_q);
                dst_data_d = hdr_byte;
                if (cnt_q == 16'd15) begin
                    cnt_d   = 16'd0;
                    state_d = (pay_len_q != 16'd0) ? S_PAYLOAD : S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_PAYLOAD: begin
                // cnt runs 0..P: reads issue for cnt<P, the write of byte cnt-1 follows its read
                if (cnt_q < pay_len_q) begin
                    src_oe_d   = 1'b1;
                    src_addr_d = src_base_q + ADDR_WIDTH'(cnt_q);
                end
                if (src_oe_q) begin
                    dst_we_d   = 1'b1;
                    pay_wr_d   = 1'b1;
                    dst_addr_d = ADDR_WIDTH'(DST_BASE) + ADDR_WIDTH'(15) + ADDR_WIDTH'(cnt_q);
                end
                if (cnt_q == pay_len_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                pkt_len_d = 16'd16 + pay_len_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_id_q   <= '0;
            elem_id_q  <= '0;
            rm_addr_q  <= '0;
            len_fld_q  <= '0;
            pay_len_q  <= '0;
            b5_q       <= '0;
            src_base_q <= '0;
            src_addr_q <= '0;
            src_oe_q   <= 1'b0;
            dst_addr_q <= '0;
            dst_data_q <= '0;
            dst_we_q   <= 1'b0;
            pay_wr_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pkt_len_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_id_q   <= acc_id_d;
            elem_id_q  <= elem_id_d;
            rm_addr_q  <= rm_addr_d;
            len_fld_q  <= len_fld_d;
            pay_len_q  <= pay_len_d;
            b5_q       <= b5_d;
            src_base_q <= src_base_d;
            src_addr_q <= src_addr_d;
            src_oe_q   <= src_oe_d;
            dst_addr_q <= dst_addr_d;
            dst_data_q <= dst_data_d;
            dst_we_q   <= dst_we_d;
            pay_wr_q   <= pay_wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pkt_len_q  <= pkt_len_d;
        end
    end

    // Payload bytes pass straight from the RAM read port to the write port
    assign dst_data = pay_wr_q ? src_data : dst_data_q;
    assign src_addr = src_addr_q;
    assign src_oe   = src_oe_q;
    assign dst_addr = dst_addr_q;
    assign dst_we   = dst_we_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pkt_len  = pkt_len_q;

endmodule

// File: tb/tb_ecpri_rma_resp_builder.sv
// Randomized bench for ecpri_rma_resp_builder against a packet-level reference model.
module tb_ecpri_rma_resp_builder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  resp_type = '0;
    logic [7:0]  acc_id = '0;
    logic [15:0] elem_id = '0;
    logic [47:0] rm_addr = '0;
    logic [15:0] rm_len = '0;
    logic [15:0] src_base = '0;
    logic [15:0] src_addr;
    logic        src_oe;
    logic [7:0]  src_data = '0;
    logic [15:0] dst_addr;
    logic [7:0]  dst_data;
    logic        dst_we;
    logic        busy;
    logic        done;
    logic [15:0] pkt_len;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  pmem [0:65535];
    logic [15:0] wr_a[$];
    logic [7:0]  wr_d[$];
    logic [15:0] rd_a[$];
    logic [7:0]  exp_q[$];
    int          done_cnt = 0;
    int          viol = 0;

    ecpri_rma_resp_builder dut (
        .clk(clk), .reset(reset), .start(start), .resp_type(resp_type),
        .acc_id(acc_id), .elem_id(elem_id), .rm_addr(rm_addr), .rm_len(rm_len),
        .src_base(src_base), .src_addr(src_addr), .src_oe(src_oe), .src_data(src_data),
        .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we),
        .busy(busy), .done(done), .pkt_len(pkt_len)
    );

    always #5 clk = ~clk;

    // Payload RAM with one-cycle read latency
    always @(posedge clk) if (src_oe) src_data <= pmem[src_addr];

    always @(negedge clk) begin
        if (dst_we) begin
            wr_a.push_back(dst_addr);
            wr_d.push_back(dst_data);
        end
        if (src_oe) rd_a.push_back(src_addr);
        if (done) done_cnt++;
        if ((dst_we || src_oe) && !busy) viol++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected packet straight from the message format; returns payload length
    task automatic build_exp(input logic [1:0] t, input logic [7:0] acc, input logic [15:0] elem,
                             input logic [47:0] ra, input logic [15:0] len, input logic [15:0] sb,
                             output int p);
        bit is_read, is_write;
        int l, psz;
        logic [7:0] b5;
        is_read  = (t == 2'd0) && (len <= 1024);
        is_write = (t == 2'd1);
        p   = is_read ? int'(len) : 0;
        l   = (is_read || is_write) ? int'(len) : 0;
        b5  = is_read ? 8'h01 : (is_write ? 8'h11 : 8'h02);
        psz = 12 + p;
        exp_q.delete();
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'(psz / 256));
        exp_q.push_back(8'(psz % 256));
        exp_q.push_back(acc);
        exp_q.push_back(b5);
        exp_q.push_back(elem[15:8]);
        exp_q.push_back(elem[7:0]);
        for (int i = 5; i >= 0; i--) exp_q.push_back(8'(ra >> (8 * i)));
        exp_q.push_back(8'(l / 256));
        exp_q.push_back(8'(l % 256));
        for (int k = 0; k < p; k++) exp_q.push_back(pmem[16'(sb + k)]);
    endtask

    task automatic fill_rand(input logic [15:0] sb, input int len);
        for (int k = 0; k < len; k++) pmem[16'(sb + k)] = 8'($urandom);
    endtask

    task automatic run_req(input logic [1:0] t, input logic [7:0] acc, input logic [15:0] elem,
                           input logic [47:0] ra, input logic [15:0] len, input logic [15:0] sb,
                           input bit collide, input bit poke);
        int p, lat, wbase, rbase, dbase, vbase, n;
        build_exp(t, acc, elem, ra, len, sb, p);
        wbase = wr_a.size();
        rbase = rd_a.size();
        dbase = done_cnt;
        vbase = viol;
        resp_type = t; acc_id = acc; elem_id = elem; rm_addr = ra; rm_len = len; src_base = sb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 4000) begin
            if (collide && lat == 5) begin
                start = 1'b1;
                acc_id = 8'h77;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("latency", lat, (p == 0) ? 18 : 19 + p);
        chk("pkt_len_done", pkt_len, 16 + p);
        chk("busy_at_done", busy, 0);
        if (poke) begin
            start = 1'b1;
            acc_id = 8'h99;
            @(negedge clk);
            start = 1'b0;
            chk("busy_after_done_start", busy, 0);
        end
        repeat (3) @(negedge clk);
        chk("busy_idle", busy, 0);
        chk("done_pulses", done_cnt - dbase, 1);
        chk("we_oe_outside_busy", viol - vbase, 0);
        chk("pkt_len_held", pkt_len, 16 + p);
        n = wr_a.size() - wbase;
        chk("wr_count", n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            chk("wr_addr", wr_a[wbase + i], i);
            chk("wr_data", wr_d[wbase + i], exp_q[i]);
        end
        n = rd_a.size() - rbase;
        chk("rd_count", n, p);
        for (int k = 0; k < n && k < p; k++) chk("rd_addr", rd_a[rbase + k], 16'(sb + k));
    endtask

    initial begin
        int p_unused, lat, dbase, len, sel;
        logic [1:0] t;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", dst_we, 0);
        chk("rst_oe", src_oe, 0);
        chk("rst_pkt_len", pkt_len, 0);
        chk("rst_dst_addr", dst_addr, 0);
        reset = 1'b0;
        @(negedge clk);

        // Read response with known payload
        pmem[16'h0200] = 8'hAA; pmem[16'h0201] = 8'hBB;
        pmem[16'h0202] = 8'hCC; pmem[16'h0203] = 8'hDD;
        run_req(2'd0, 8'h5A, 16'h1234, 48'h0000_0000_1000, 16'd4, 16'h0200, 1'b0, 1'b0);
        // Write response, oversize read, zero-length read
        run_req(2'd1, 8'h21, 16'hBEEF, 48'h1122_3344_5566, 16'd64, 16'h0000, 1'b0, 1'b0);
        run_req(2'd0, 8'h33, 16'h0001, 48'hFFFF_0000_FFFF, 16'd1025, 16'h0000, 1'b0, 1'b0);
        run_req(2'd0, 8'h44, 16'h0002, 48'h0, 16'd0, 16'h0000, 1'b0, 1'b0);
        // Largest legal read, wrapping source address
        fill_rand(16'hFE00, 1024);
        run_req(2'd0, 8'h45, 16'hA5A5, 48'hABCD_EF01_2345, 16'd1024, 16'hFE00, 1'b0, 1'b0);
        // Collision while busy, then start during the done cycle
        fill_rand(16'h0400, 8);
        run_req(2'd0, 8'h11, 16'h0F0F, 48'h42, 16'd8, 16'h0400, 1'b1, 1'b1);
        run_req(2'd3, 8'h12, 16'h7777, 48'h99, 16'd5, 16'h0000, 1'b1, 1'b0);

        // Reset during payload byte 2 write
        fill_rand(16'h0800, 8);
        resp_type = 2'd0; acc_id = 8'h66; rm_len = 16'd8; src_base = 16'h0800;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (lat < 21) begin
            @(negedge clk);
            lat++;
        end
        chk("pre_reset_we", dst_we, 1);
        dbase = done_cnt;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_we", dst_we, 0);
        chk("mid_rst_oe", src_oe, 0);
        chk("mid_rst_dst_data", dst_data, 0);
        chk("mid_rst_dst_addr", dst_addr, 0);
        chk("mid_rst_src_addr", src_addr, 0);
        chk("mid_rst_pkt_len", pkt_len, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        chk("no_done_after_abort", done_cnt - dbase, 0);
        run_req(2'd0, 8'h67, 16'h5555, 48'h1234_5678_9ABC, 16'd8, 16'h0800, 1'b0, 1'b0);

        for (int it = 0; it < 16; it++) begin
            logic [15:0] sb;
            t = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 5);
            case (sel)
                0: len = 0;
                1: len = 1024;
                2: len = 1025;
                3: len = $urandom_range(1, 40);
                4: len = $urandom_range(1000, 1100);
                default: len = $urandom_range(1, 300);
            endcase
            sb = 16'($urandom);
            fill_rand(sb, len);
            run_req(t, 8'($urandom), 16'($urandom), {16'($urandom), 32'($urandom)},
                    16'(len), sb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        p_unused = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ecpri_rma_resp_builder.md
Name: ecpri_rma_resp_builder

Overview:
- Parametrised eCPRI Remote Memory Access (msg type 4) response packet builder.
- Sits between the eCPRI RX request decoder and the Ethernet TX framer.
- Builds read-response, write-response and failure packets byte-serially into the TX packet RAM. Read responses copy payload from the payload RAM.
- Adds a start/busy/done handshake, length checking, failure responses and a reported packet length.

Parameters:
- ADDR_WIDTH, 16, address width of source and destination RAM ports.
- MAX_LEN, 1024, largest read payload in bytes; requests above this get a failure response.
- DST_BASE, 0, destination RAM address of packet byte 0.
- ECPRI_REV, 1, eCPRI revision placed in byte 0 bits [7:4].

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to build a response; ignored while busy.
- resp_type  in  2  response kind: 0 = read response, 1 = write response, 2 = failure, 3 = treated as failure.
- acc_id  in  8  Remote Memory Access ID to echo.
- elem_id  in  16  Element ID to echo.
- rm_addr  in  48  remote address to echo.
- rm_len  in  16  requested length in bytes.
- src_base  in  ADDR_WIDTH  payload RAM address of the first read-data byte.
- src_addr  out  ADDR_WIDTH  payload RAM read address.
- src_oe  out  1  payload RAM read enable.
- src_data  in  8  payload RAM read data; valid one cycle after src_oe.
- dst_addr  out  ADDR_WIDTH  packet RAM write address.
- dst_data  out  8  packet RAM write data.
- dst_we  out  1  packet RAM write enable.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the packet is complete.
- pkt_len  out  16  total bytes written (header + payload); held until the next accepted start.

Behaviour:
- Reset (async): state IDLE; all outputs 0; all latched fields 0.
- Reset asserted mid-packet aborts the packet. No done pulse is issued. Bytes already written stay in the RAM.
- IDLE:
  - start=1 latches all request inputs and sets busy=1 on the next edge.
  - The effective type is resolved as follows:
    - resp_type 0 with rm_len > MAX_LEN becomes failure.
    - resp_type 0 with rm_len = 0 stays a read response with no payload.
    - resp_type 3 becomes failure.
  - Payload length P = rm_len for a read response, otherwise 0.
  - Length field L: read = rm_len; write = rm_len; failure = 0.
  - Then go to HDR.
- HDR: 16 cycles, one byte per cycle, dst_we=1, dst_addr = DST_BASE + i, i = 0..15.
  - Byte 0 = {ECPRI_REV[3:0], 4'b0000}.
  - Byte 1 = 8'h04.
  - Bytes 2–3 = payload size (12 + P), MSB first.
  - Byte 4 = acc_id.
  - Byte 5 = {rw, req_resp}. Read response = 8'h01, write response = 8'h11, failure = 8'h02 for a read request, 8'h12 for a write request.
  - Bytes 6–7 = elem_id, MSB first.
  - Bytes 8–13 = rm_addr[47:0], MSB first.
  - Bytes 14–15 = L, MSB first.
  - After byte 15: go to PAYLOAD if P > 0, otherwise DONE.
- PAYLOAD: pipelined copy with one-cycle read latency.
  - src_oe=1 with src_addr = src_base + k for k = 0..P-1 on consecutive cycles.
  - Byte k is written at dst_addr = DST_BASE + 16 + k, one cycle after its read.
  - Throughput is 1 byte/cycle; the last write occurs P+1 cycles after PAYLOAD entry.
  - src_oe deasserts after the final read; dst_we deasserts after the final write.
- DONE: one cycle with done=1 and busy=0, then IDLE.
  - pkt_len = 16 + P, valid from the done cycle.
- Latency:
  - start to done = 18 cycles when P = 0.
  - start to done = 19 + P cycles when P > 0.
- start while busy: ignored; latched fields are unchanged.
- start in the DONE cycle: ignored.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- dst_we and src_oe are never high outside HDR/PAYLOAD.

Test Plan:
- Read response: reset, then start with type 0, acc_id 8'h5A, elem_id 16'h1234, rm_addr 48'h0000_0000_1000, rm_len 4, payload RAM [src_base..+3] = AA BB CC DD.
  - Packet RAM = 10 04 00 10 5A 01 12 34 00 00 00 00 10 00 00 04 AA BB CC DD.
  - pkt_len = 20; done 23 cycles after start.
- Write response: type 1, rm_len 64.
  - 16 header bytes; byte 5 = 11; bytes 2–3 = 00 0C; bytes 14–15 = 00 40.
  - No src_oe; pkt_len = 16; done 18 cycles after start.
- Oversize read: type 0, rm_len 1025 (MAX_LEN 1024).
  - Byte 5 = 02; bytes 14–15 = 00 00; no payload reads; pkt_len = 16.
- Busy collision: second start (acc_id 8'h77) 5 cycles after the first.
  - Ignored; byte 4 keeps the first acc_id; exactly one done pulse.
- Mid-packet reset: assert reset during PAYLOAD byte 2.
  - All outputs 0 immediately; no done pulse.
  - A subsequent start builds a complete correct packet.
- Zero-length read: type 0, rm_len 0.
  - Byte 5 = 01; bytes 2–3 = 00 0C; no src_oe; pkt_len = 16.
